keypad_scanner: RTL and testbench

Parametrised matrix-keypad scanner with per-key debounce, press/release event pulses and multi-key detection. It drives one column at a time, samples the active-low rows through a synchroniser and reports a single debounced key code. It sits between the board keypad pins and the countdown control logic, and generalises the fixed 4x4 non-debounced scanner to arbitrary matrix sizes.

---
 rtl/keypad_scanner.sv | 248 ++++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner
// Description : Matrix-keypad scanner. Drives one column low at a time,
//               samples the active-low rows through a 2-flop synchroniser,
//               accumulates per-frame hit information and debounces a single
//               key code with press/release pulses and multi-key detection.
// Ports       : scan_clk    - scan clock, all state on rising edge
//               rst_n       - asynchronous active-low reset
//               row_n       - row sense lines, active-low
//               col_n       - column drives, one-cold
//               keydown     - debounced key held (level)
//               key         - accepted key code = row*COLS + col
//               press       - one-cycle pulse when a key is accepted
//               key_release - one-cycle pulse when the held key is released
//               multi       - two or more closed switches in last frame
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int DWELL    = 3,
    parameter int DEBOUNCE = 3,
    localparam int KEY_W   = $clog2(ROWS * COLS)
) (
    input  logic             scan_clk,
    input  logic             rst_n,
    input  logic [ROWS-1:0]  row_n,
    output logic [COLS-1:0]  col_n,
    output logic             keydown,
    output logic [KEY_W-1:0] key,
    output logic             press,
    output logic             key_release,
    output logic             multi
);

    localparam int               c_COL_W      = $clog2(COLS);
    localparam int               c_DW_W       = $clog2(DWELL);
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(COLS - 1);
    localparam logic [c_DW_W-1:0]  c_DW_LAST  = c_DW_W'(DWELL - 1);
    localparam logic [3:0]         c_DEB      = 4'(DEBOUNCE);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_DB_PRESS   = 2'd1,
        S_HELD       = 2'd2,
        S_DB_RELEASE = 2'd3
    } state_t;

    // Scan counters and synchroniser
    logic [c_COL_W-1:0] r_col_idx;
    logic [c_DW_W-1:0]  r_dwell;
    logic [ROWS-1:0]    r_row_s1;
    logic [ROWS-1:0]    r_row_s2;

    // Per-frame accumulators (hit count saturates at 2)
    logic [1:0]         r_acc_hits;
    logic               r_acc_found;
    logic [KEY_W-1:0]   r_acc_code;
    logic               r_acc_seen;

    // Debounce state
    state_t             r_state;
    logic [3:0]         r_cnt;
    logic [KEY_W-1:0]   r_cand;

    logic               w_sample;
    logic               w_frame_end;
    logic [1:0]         w_col_hits;
    logic               w_col_found;
    logic [KEY_W-1:0]   w_col_code;
    logic               w_col_seen;
    logic [2:0]         w_hit_sum;
    logic [1:0]         w_frame_hits;
    logic               w_frame_found;
    logic [KEY_W-1:0]   w_frame_code;
    logic               w_frame_seen;
    logic [3:0]         w_cnt_inc;

    assign w_sample    = (r_dwell == c_DW_LAST);
    assign w_frame_end = w_sample && (r_col_idx == c_COL_LAST);
    assign w_cnt_inc   = r_cnt + 4'd1;

    // One-cold column drive decoded from the column counter
    generate
        for (genvar c = 0; c < COLS; c++) begin : g_col_drv
            assign col_n[c] = (r_col_idx != c_COL_W'(c));
        end
    endgenerate

    // Contribution of the currently driven column. Rows are walked from the
    // top down so the lowest closed row (lowest code in this column) wins.
    always_comb begin
        w_col_hits  = 2'd0;
        w_col_found = 1'b0;
        w_col_code  = '0;
        w_col_seen  = 1'b0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (!r_row_s2[r]) begin
                w_col_found = 1'b1;
                w_col_code  = KEY_W'(r * COLS + int'(r_col_idx));
                if (KEY_W'(r * COLS + int'(r_col_idx)) == r_cand) begin
                    w_col_seen = 1'b1;
                end
                if (w_col_hits != 2'd2) begin
                    w_col_hits = w_col_hits + 2'd1;
                end
            end
        end
    end

    // Frame results including the column being sampled this cycle, so the
    // FSM sees the complete frame on the frame-end edge.
    always_comb begin
        w_hit_sum     = {1'b0, r_acc_hits} + {1'b0, w_col_hits};
        w_frame_hits  = (w_hit_sum >= 3'd2) ? 2'd2 : w_hit_sum[1:0];
        w_frame_found = r_acc_found | w_col_found;
        w_frame_seen  = r_acc_seen | w_col_seen;
        if (r_acc_found && (!w_col_found || (r_acc_code < w_col_code))) begin
            w_frame_code = r_acc_code;
        end else begin
            w_frame_code = w_col_code;
        end
    end

    // Scan counters, synchroniser and frame accumulators
    always_ff @(posedge scan_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_idx   <= '0;
            r_dwell     <= '0;
            r_row_s1    <= '1;
            r_row_s2    <= '1;
            r_acc_hits  <= 2'd0;
            r_acc_found <= 1'b0;
            r_acc_code  <= '0;
            r_acc_seen  <= 1'b0;
        end else begin
            r_row_s1 <= row_n;
            r_row_s2 <= r_row_s1;

            if (w_sample) begin
                r_dwell   <= '0;
                r_col_idx <= (r_col_idx == c_COL_LAST) ? '0 : r_col_idx + 1'b1;
            end else begin
                r_dwell <= r_dwell + 1'b1;
            end

            if (w_frame_end) begin
                r_acc_hits  <= 2'd0;
                r_acc_found <= 1'b0;
                r_acc_code  <= '0;
                r_acc_seen  <= 1'b0;
            end else if (w_sample) begin
                r_acc_hits  <= w_frame_hits;
                r_acc_found <= w_frame_found;
                r_acc_code  <= w_frame_code;
                r_acc_seen  <= w_frame_seen;
            end
        end
    end

    // Debounce FSM with registered outputs, evaluated once per frame
    always_ff @(posedge scan_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_cand      <= '0;
            keydown     <= 1'b0;
            key         <= '0;
            press       <= 1'b0;
            key_release <= 1'b0;
            multi       <= 1'b0;
        end else begin
            press       <= 1'b0;
            key_release <= 1'b0;
            if (w_frame_end) begin
                multi <= (w_frame_hits == 2'd2);
                case (r_state)
                    S_IDLE: begin
                        // Exactly one hit: two keys at once never start a press
                        if (w_frame_hits == 2'd1) begin
                            r_cand <= w_frame_code;
                            if (DEBOUNCE == 1) begin
                                key     <= w_frame_code;
                                keydown <= 1'b1;
                                press   <= 1'b1;
                                r_cnt   <= 4'd0;
                                r_state <= S_HELD;
                            end else begin
                                r_cnt   <= 4'd1;
                                r_state <= S_DB_PRESS;
                            end
                        end
                    end
                    S_DB_PRESS: begin
                        if ((w_frame_hits == 2'd1) && (w_frame_code == r_cand)) begin
                            if (w_cnt_inc == c_DEB) begin
                                key     <= r_cand;
                                keydown <= 1'b1;
                                press   <= 1'b1;
                                r_cnt   <= 4'd0;
                                r_state <= S_HELD;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end else begin
                            r_cnt   <= 4'd0;
                            r_state <= S_IDLE;
                        end
                    end
                    S_HELD: begin
                        // Extra keys are ignored while the candidate stays closed
                        if (!w_frame_seen) begin
                            if (DEBOUNCE == 1) begin
                                keydown     <= 1'b0;
                                key_release <= 1'b1;
                                r_cnt       <= 4'd0;
                                r_state     <= S_IDLE;
                            end else begin
                                r_cnt   <= 4'd1;
                                r_state <= S_DB_RELEASE;
                            end
                        end
                    end
                    S_DB_RELEASE: begin
                        if (w_frame_seen) begin
                            r_cnt   <= 4'd0;
                            r_state <= S_HELD;
                        end else if (w_cnt_inc == c_DEB) begin
                            keydown     <= 1'b0;
                            key_release <= 1'b1;
                            r_cnt       <= 4'd0;
                            r_state     <= S_IDLE;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    default: begin
                        r_cnt   <= 4'd0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scanner
// Description : Directed testbench for keypad_scanner. A behavioural keypad
//               closes switches in a 4x4 matrix; two scanner instances
//               (DEBOUNCE=3 and DEBOUNCE=1) share clock, reset and switches.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

    logic        scan_clk;
    logic        rst_n;
    logic [15:0] closed;

    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic        keydown;
    logic [3:0]  key;
    logic        press;
    logic        key_release;
    logic        multi;

    logic [3:0]  row_n1;
    logic [3:0]  col_n1;
    logic        keydown1;
    logic [3:0]  key1;
    logic        press1;
    logic        key_release1;
    logic        multi1;

    int n_checks;
    int n_errors;
    logic seen_press;
    logic seen_release;
    logic seen_press1;
    logic seen_release1;

    keypad_scanner #(
        .ROWS(4), .COLS(4), .DWELL(3), .DEBOUNCE(3)
    ) dut (
        .scan_clk(scan_clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n),
        .keydown(keydown), .key(key), .press(press),
        .key_release(key_release), .multi(multi)
    );

    keypad_scanner #(
        .ROWS(4), .COLS(4), .DWELL(3), .DEBOUNCE(1)
    ) dut1 (
        .scan_clk(scan_clk), .rst_n(rst_n), .row_n(row_n1), .col_n(col_n1),
        .keydown(keydown1), .key(key1), .press(press1),
        .key_release(key_release1), .multi(multi1)
    );

    initial scan_clk = 1'b0;
    always #5 scan_clk = ~scan_clk;

    // Switch matrix: a closed switch pulls its row low while its column is driven
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (closed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    always_comb begin
        row_n1 = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (closed[r*4+c] && !col_n1[c]) row_n1[r] = 1'b0;
    end

    task automatic check_value(input string tag, input logic [31:0] obs,
                               input logic [31:0] expected);
        n_checks++;
        if (obs !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expected);
        end
    endtask

    // Advance n clock cycles, sampling pulses on each falling edge
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge scan_clk);
            seen_press    = seen_press | press;
            seen_release  = seen_release | key_release;
            seen_press1   = seen_press1 | press1;
            seen_release1 = seen_release1 | key_release1;
        end
    endtask

    task automatic clear_seen();
        seen_press    = 1'b0;
        seen_release  = 1'b0;
        seen_press1   = 1'b0;
        seen_release1 = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        clear_seen();
        closed = 16'h0;
        rst_n  = 1'b0;

        // Reset values before any clock edge
        #1;
        check_value("rst_col_n", col_n, 4'b1110);
        check_value("rst_keydown", keydown, 0);
        check_value("rst_key", key, 0);
        check_value("rst_press", press, 0);
        check_value("rst_release", key_release, 0);
        check_value("rst_multi", multi, 0);

        // Clean press of key 9 (row 2, col 1) from frame 0
        @(negedge scan_clk);
        closed[9] = 1'b1;
        rst_n = 1'b1;
        step(3);  check_value("col_walk_1", col_n, 4'b1101);
        step(3);  check_value("col_walk_2", col_n, 4'b1011);
        step(3);  check_value("col_walk_3", col_n, 4'b0111);
        step(3);  check_value("col_walk_wrap", col_n, 4'b1110);
        check_value("deb1_press_frame0", press1, 1);
        clear_seen();
        step(23);
        check_value("no_early_press", seen_press, 0);
        check_value("no_early_keydown", keydown, 0);
        step(1);                                   // edge 36
        check_value("press_pulse", press, 1);
        check_value("press_key", key, 9);
        check_value("press_keydown", keydown, 1);
        step(1);
        check_value("press_one_cycle", press, 0);

        // Release after three open frames
        step(11);                                  // edge 48
        closed[9] = 1'b0;
        clear_seen();
        step(35);                                  // edge 83
        check_value("no_early_release", seen_release, 0);
        check_value("held_before_release", keydown, 1);
        step(1);                                   // edge 84
        check_value("release_pulse", key_release, 1);
        check_value("release_keydown", keydown, 0);
        check_value("release_key_kept", key, 9);
        step(1);
        check_value("release_one_cycle", key_release, 0);

        // Re-press, then alternate open/closed frames: no release
        step(11);                                  // edge 96
        closed[9] = 1'b1;
        step(36);                                  // edge 132
        check_value("repress_pulse", press, 1);
        clear_seen();
        for (int k = 0; k < 4; k++) begin
            closed[9] = (k % 2 == 1);
            step(12);
        end
        step(12);                                  // edge 192
        check_value("alt_no_release", seen_release, 0);
        check_value("alt_keydown", keydown, 1);

        // Second key (row 3, col 2 = 14) while 9 is held
        closed[14] = 1'b1;
        clear_seen();
        step(11);                                  // edge 203
        check_value("multi_before_frame_end", multi, 0);
        step(1);                                   // edge 204
        check_value("multi_set", multi, 1);
        check_value("multi_key_kept", key, 9);
        check_value("multi_keydown", keydown, 1);
        closed[9]  = 1'b0;
        closed[14] = 1'b0;
        step(12);                                  // edge 216
        check_value("multi_cleared", multi, 0);
        step(24);                                  // edge 240
        check_value("multi_no_extra_press", seen_press, 0);
        check_value("release_after_multi", key_release, 1);
        check_value("key_after_multi", key, 9);

        // Keys 5 and 6 together from IDLE: multi, never a press
        closed[5] = 1'b1;
        closed[6] = 1'b1;
        clear_seen();
        step(12);                                  // edge 252
        check_value("two_keys_multi", multi, 1);
        step(48);                                  // edge 300
        check_value("two_keys_no_press", seen_press, 0);
        check_value("two_keys_no_keydown", keydown, 0);

        // Asynchronous reset mid-frame
        step(4);                                   // col_idx = 1
        #2 rst_n = 1'b0;
        #1;
        check_value("async_rst_col_n", col_n, 4'b1110);
        check_value("async_rst_key", key, 0);
        check_value("async_rst_multi", multi, 0);
        check_value("async_rst_keydown", keydown, 0);

        // Bounce: key 9 closed for frames 0-1 only
        closed = 16'h0;
        closed[9] = 1'b1;
        step(2);
        rst_n = 1'b1;
        clear_seen();
        step(12);                                  // edge 12
        check_value("deb1_bounce_press", press1, 1);
        check_value("deb1_bounce_key", key1, 9);
        step(12);                                  // edge 24
        closed[9] = 1'b0;
        step(12);                                  // edge 36
        check_value("deb1_bounce_release", key_release1, 1);
        step(24);                                  // edge 60
        check_value("bounce_no_press", seen_press, 0);
        check_value("bounce_no_keydown", keydown, 0);

        // Reset while key 9 is held, press re-issued afterwards
        closed[9] = 1'b1;
        step(40);                                  // edge 100, press at 96
        check_value("held_before_reset", keydown, 1);
        #2 rst_n = 1'b0;
        #1;
        check_value("held_rst_keydown", keydown, 0);
        check_value("held_rst_key", key, 0);
        step(2);
        rst_n = 1'b1;
        clear_seen();
        step(35);
        check_value("rerst_no_early_press", seen_press, 0);
        step(1);                                   // edge 36
        check_value("rerst_press", press, 1);
        check_value("rerst_key", key, 9);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
